// File: rtl/param_sync_fifo.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow flags,
// synchronous flush and selectable standard or first-word-fall-through
// read mode. Single clock, synchronous active-high reset.
module param_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_acc;
    logic             wr_acc;

    // Status flags are plain decodes of the registered occupancy, so they
    // show the effect of an accept one cycle after the accepting edge.
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // Handshake: a read is accepted when rd_en is high and the FIFO holds at
    // least one word; a write is accepted when wr_en is high and there is
    // room, or when a read is accepted in the same cycle (pass-through at
    // full). Requests that are not accepted are dropped and flagged. A word
    // written at edge N is never visible to a read at edge N (no bypass).
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Pointer and occupancy update; rst beats flush beats normal traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; not reset, written only on an accepted write.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Sticky error flags; a new error event wins over clr_err, flush freezes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            overflow  <= (wr_en & ~wr_acc) | (overflow  & ~clr_err);
            underflow <= (rd_en & ~rd_acc) | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented directly; rd_en only pops it.
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            // Registered read: data appears the cycle after an accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule
